alu_seq: RTL

//   Parametrised, registered successor to the 4-bit combinational ALU: same 8 base ops ({m,s1,s0}),

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: op codes, flag bit positions,
// FSM state encodings and a flag packing helper.
package alu_pkg;

  // Op codes {ext,m,s1,s0}; ext=0 is the legacy 8-op set, 11xx is illegal.
  localparam logic [3:0] OP_NOT = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  // Bit positions inside the 5-bit flags word.
  localparam int FLG_ZERO    = 0;
  localparam int FLG_CARRY   = 1;
  localparam int FLG_OVF     = 2;
  localparam int FLG_NEG     = 3;
  localparam int FLG_ILLEGAL = 4;

  // Sequencer states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  function automatic logic [4:0] pack_flags(input logic ill, input logic neg,
                                            input logic ovf, input logic carry,
                                            input logic zero);
    logic [4:0] f;
    f              = '0;
    f[FLG_ILLEGAL] = ill;
    f[FLG_NEG]     = neg;
    f[FLG_OVF]     = ovf;
    f[FLG_CARRY]   = carry;
    f[FLG_ZERO]    = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of the registered ALU.
//
// Handshake: both channels are valid/ready. A transfer happens on a rising
// edge where valid && ready are both high. The producer holds its payload
// stable while valid is high and ready is low; ready may depend on the
// other channel's ready combinationally (in_ready depends on out_ready),
// never on the same channel's valid.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  // master: operand source and result consumer; slave: the ALU itself.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// WIDTH iterations after start. done_o and product_o are combinational so
// the caller can capture the full product on the edge of the last iteration.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Next accumulator: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  // Operand capture on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith/shift ops, optional iterative
// multiply, and a one-entry output register carrying result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [0:0] dbg_state_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [0:0]         state_q, state_d;
  logic               accept, is_mul_op, load_single, load_mul;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     ext_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s, ovf_s, ill_s;
  logic [4:0]         flags_s;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_hi;
  logic [4:0]         mul_flags;
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         flags_q;
  logic               out_valid_q;

  assign sh          = bus.b[SHW-1:0];
  assign is_mul_op   = (bus.op == OP_MUL) && (ENABLE_MUL != 0);
  // Only take new operands when idle and the output slot is free or being drained.
  assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept      = bus.in_valid && bus.in_ready;
  assign load_single = accept && !is_mul_op;
  assign load_mul    = (state_q == ST_MUL) && mul_done;

  // Single-cycle datapath; ext_s carries the extra bit used for carry/borrow/shift-out.
  always_comb begin
    ext_s   = '0;
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    ill_s   = 1'b0;
    case (bus.op)
      OP_NOT: res_s = ~bus.a;
      OP_AND: res_s = bus.a & bus.b;
      OP_XOR: res_s = bus.a ^ bus.b;
      OP_OR:  res_s = bus.a | bus.b;
      OP_DEC: begin
        ext_s   = {1'b0, bus.a} - (WIDTH+1)'(1);
        res_s   = ext_s[WIDTH-1:0];
        carry_s = ext_s[WIDTH];
        ovf_s   = bus.a[MSB] && !res_s[MSB];
      end
      OP_ADD: begin
        ext_s   = {1'b0, bus.a} + {1'b0, bus.b};
        res_s   = ext_s[WIDTH-1:0];
        carry_s = ext_s[WIDTH];
        ovf_s   = (bus.a[MSB] == bus.b[MSB]) && (res_s[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        ext_s   = {1'b0, bus.a} - {1'b0, bus.b};
        res_s   = ext_s[WIDTH-1:0];
        carry_s = ext_s[WIDTH];
        ovf_s   = (bus.a[MSB] != bus.b[MSB]) && (res_s[MSB] != bus.a[MSB]);
      end
      OP_INC: begin
        ext_s   = {1'b0, bus.a} + (WIDTH+1)'(1);
        res_s   = ext_s[WIDTH-1:0];
        carry_s = ext_s[WIDTH];
        ovf_s   = !bus.a[MSB] && res_s[MSB];
      end
      OP_SHL: begin
        ext_s   = {1'b0, bus.a} << sh;
        res_s   = ext_s[WIDTH-1:0];
        carry_s = ext_s[WIDTH];
      end
      OP_SHR: begin
        ext_s   = {bus.a, 1'b0} >> sh;
        res_s   = ext_s[WIDTH:1];
        carry_s = ext_s[0];
      end
      OP_SAR: begin
        ext_s   = $signed({bus.a, 1'b0}) >>> sh;
        res_s   = ext_s[WIDTH:1];
        carry_s = ext_s[0];
      end
      OP_MUL: begin
        // With the multiplier present this op goes through the sequencer instead.
        if (ENABLE_MUL == 0) ill_s = 1'b1;
      end
      default: ill_s = 1'b1;
    endcase
    flags_s = ill_s ? pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)
                    : pack_flags(1'b0, res_s[MSB], ovf_s, carry_s, res_s == '0);
  end

  if (ENABLE_MUL != 0) begin : g_mul
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (accept && is_mul_op),
      .a_i       (bus.a),
      .b_i       (bus.b),
      .done_o    (mul_done),
      .product_o (mul_product)
    );
  end else begin : g_no_mul
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  assign mul_res   = mul_product[WIDTH-1:0];
  assign mul_hi    = |mul_product[2*WIDTH-1:WIDTH];
  assign mul_flags = pack_flags(1'b0, mul_res[MSB], mul_hi, mul_hi, mul_res == '0);

  // Sequencer: leave IDLE only for an accepted multiply, return on its last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul_op) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output slot: load a new result, otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (load_single) begin
      result_q    <= res_s;
      flags_q     <= flags_s;
      out_valid_q <= 1'b1;
    end else if (load_mul) begin
      result_q    <= mul_res;
      flags_q     <= mul_flags;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dbg_state_o   = state_q;

endmodule
